accel_result_writer: RTL and testbench

//  DMA write-back engine for the INT8 matmul datapath. Accepts 4-lane INT32 results,

---
 rtl/accel_result_writer_if.sv | 39 +++
 rtl/accel_result_writer.sv | 245 ++++++++++++++++++++++++
 tb/tb_accel_result_writer.sv | 427 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/accel_result_writer_if.sv
// Bundle of the result writer's MMIO, result-stream and DMA write-port signals.
// master = the result writer; slave = the CPU / datapath / memory-arbiter side.
interface accel_result_writer_if;
  logic         mmio_sel;
  logic [31:0]  mmio_addr;
  logic [31:0]  mmio_wdata;
  logic [3:0]   mmio_we;
  logic         mmio_re;
  logic [31:0]  mmio_rdata;

  logic         res_valid;
  logic [127:0] res_data;
  logic         res_ready;

  logic         dma_wr_valid;
  logic         dma_wr_ready;
  logic [31:0]  dma_addr;
  logic [127:0] dma_wdata;
  logic [15:0]  dma_we;
  logic         wb_busy;

  modport master (
    input  mmio_sel, mmio_addr, mmio_wdata, mmio_we, mmio_re,
    output mmio_rdata,
    input  res_valid, res_data,
    output res_ready,
    output dma_wr_valid, dma_addr, dma_wdata, dma_we, wb_busy,
    input  dma_wr_ready
  );

  modport slave (
    output mmio_sel, mmio_addr, mmio_wdata, mmio_we, mmio_re,
    input  mmio_rdata,
    output res_valid, res_data,
    input  res_ready,
    input  dma_wr_valid, dma_addr, dma_wdata, dma_we, wb_busy,
    output dma_wr_ready
  );
endinterface

// File: rtl/accel_result_writer.sv
// Result write-back engine: requantizes 4-lane INT32 beats to INT8, packs 16-byte lines, writes them via DMA.
// Optional macro ACCEL_WB_RELU_EN clamps negative requantized values to 0 before saturation.
module accel_result_writer #(
  parameter int CNT_W   = 16,
  parameter int SCALE_W = 16
) (
  input logic clk,
  input logic reset,
  accel_result_writer_if.master bus
);

  localparam int PROD_W = 32 + SCALE_W;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COLLECT = 2'd1;
  localparam logic [1:0] ST_WRITE   = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  localparam logic [7:0] OFF_CTRL    = 8'h00;
  localparam logic [7:0] OFF_DST     = 8'h04;
  localparam logic [7:0] OFF_COUNT   = 8'h08;
  localparam logic [7:0] OFF_SCALE   = 8'h0C;
  localparam logic [7:0] OFF_SHIFT   = 8'h10;
  localparam logic [7:0] OFF_WRITTEN = 8'h14;

  logic [1:0]         state_reg;
  logic               done_reg;
  logic [31:0]        cfg_dst_reg;
  logic [CNT_W-1:0]   cfg_count_reg;
  logic [SCALE_W-1:0] cfg_scale_reg;
  logic [4:0]         cfg_shift_reg;
  logic [SCALE_W-1:0] run_scale_reg;
  logic [4:0]         run_shift_reg;
  logic [31:0]        addr_reg;
  logic [CNT_W-1:0]   remaining_reg;
  logic [CNT_W-1:0]   written_reg;
  logic [1:0]         beat_idx_reg;
  logic [127:0]       line_data_reg;
  logic [15:0]        line_we_reg;
  logic [4:0]         line_bytes_reg;
  logic [31:0]        rdata_reg;

  logic [7:0] offset;
  logic       reg_wr;
  logic       ctrl_wr;
  logic       abort_cmd;
  logic       start_cmd;
  logic       launch;
  logic       busy;
  logic       unused_addr_bits;

  assign offset           = bus.mmio_addr[7:0];
  assign reg_wr           = bus.mmio_sel && (bus.mmio_we != 4'b0000);
  assign ctrl_wr          = reg_wr && (offset == OFF_CTRL);
  assign abort_cmd        = ctrl_wr && bus.mmio_wdata[1];
  assign start_cmd        = ctrl_wr && bus.mmio_wdata[0] && !bus.mmio_wdata[1];
  assign launch           = start_cmd && ((state_reg == ST_IDLE) || (state_reg == ST_DONE));
  assign busy             = (state_reg == ST_COLLECT) || (state_reg == ST_WRITE);
  assign unused_addr_bits = ^bus.mmio_addr[31:8];

  // Scale, round-half-up, arithmetic shift, then saturate to one byte.
  function automatic logic [7:0] requant(input logic [31:0] acc,
                                         input logic [SCALE_W-1:0] scale,
                                         input logic [4:0] shift);
    logic signed [PROD_W-1:0] p;
    logic signed [PROD_W-1:0] q;
    p = PROD_W'($signed(acc)) * PROD_W'($signed(scale));
    if (shift != 5'd0) begin
      p = p + (PROD_W'(1) <<< (shift - 5'd1));
    end
    q = p >>> shift;
`ifdef ACCEL_WB_RELU_EN
    if (q[PROD_W-1]) begin
      q = '0;
    end
`endif
    if (q > PROD_W'(127)) begin
      return 8'h7F;
    end else if (q < PROD_W'(-128)) begin
      return 8'h80;
    end
    return q[7:0];
  endfunction

  logic [7:0]       lane_byte [4];
  logic [3:0]       lane_en;
  logic [2:0]       beat_take;
  logic [CNT_W-1:0] remaining_after;
  logic [127:0]     merged_data;
  logic [15:0]      merged_we;
  logic [4:0]       merged_bytes;
  logic             beat_fire;
  logic             line_close;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign lane_byte[gi] = requant(bus.res_data[32*gi +: 32], run_scale_reg, run_shift_reg);
      // Lanes beyond the remaining element count are dropped.
      assign lane_en[gi]   = remaining_reg > CNT_W'(gi);
    end
  endgenerate

  always_comb begin
    beat_take    = 3'd0;
    merged_data  = line_data_reg;
    merged_we    = line_we_reg;
    for (int k = 0; k < 4; k++) begin
      if (lane_en[k]) begin
        beat_take = beat_take + 3'd1;
        merged_data[(4 * int'(beat_idx_reg) + k) * 8 +: 8] = lane_byte[k];
        merged_we[4 * int'(beat_idx_reg) + k] = 1'b1;
      end
    end
    merged_bytes    = line_bytes_reg + 5'(beat_take);
    remaining_after = remaining_reg - CNT_W'(beat_take);
  end

  assign beat_fire  = (state_reg == ST_COLLECT) && bus.res_valid;
  assign line_close = (beat_idx_reg == 2'd3) || (remaining_after == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      cfg_dst_reg   <= '0;
      cfg_count_reg <= '0;
      cfg_scale_reg <= '0;
      cfg_shift_reg <= '0;
    end else if (reg_wr) begin
      case (offset)
        OFF_DST:   cfg_dst_reg   <= {bus.mmio_wdata[31:4], 4'b0000};
        OFF_COUNT: cfg_count_reg <= bus.mmio_wdata[CNT_W-1:0];
        OFF_SCALE: cfg_scale_reg <= bus.mmio_wdata[SCALE_W-1:0];
        OFF_SHIFT: cfg_shift_reg <= bus.mmio_wdata[4:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      done_reg       <= 1'b0;
      run_scale_reg  <= '0;
      run_shift_reg  <= '0;
      addr_reg       <= '0;
      remaining_reg  <= '0;
      written_reg    <= '0;
      beat_idx_reg   <= '0;
      line_data_reg  <= '0;
      line_we_reg    <= '0;
      line_bytes_reg <= '0;
    end else if (abort_cmd) begin
      state_reg      <= ST_IDLE;
      done_reg       <= 1'b0;
      beat_idx_reg   <= '0;
      line_data_reg  <= '0;
      line_we_reg    <= '0;
      line_bytes_reg <= '0;
    end else if (launch) begin
      // Snapshot the configuration so later MMIO writes cannot disturb this run.
      run_scale_reg  <= cfg_scale_reg;
      run_shift_reg  <= cfg_shift_reg;
      addr_reg       <= cfg_dst_reg;
      remaining_reg  <= cfg_count_reg;
      written_reg    <= '0;
      beat_idx_reg   <= '0;
      line_data_reg  <= '0;
      line_we_reg    <= '0;
      line_bytes_reg <= '0;
      if (cfg_count_reg == '0) begin
        state_reg <= ST_DONE;
        done_reg  <= 1'b1;
      end else begin
        state_reg <= ST_COLLECT;
        done_reg  <= 1'b0;
      end
    end else begin
      case (state_reg)
        ST_COLLECT: begin
          if (beat_fire) begin
            line_data_reg  <= merged_data;
            line_we_reg    <= merged_we;
            line_bytes_reg <= merged_bytes;
            remaining_reg  <= remaining_after;
            beat_idx_reg   <= beat_idx_reg + 2'd1;
            if (line_close) begin
              state_reg <= ST_WRITE;
            end
          end
        end
        ST_WRITE: begin
          if (bus.dma_wr_ready) begin
            addr_reg       <= addr_reg + 32'd16;
            written_reg    <= written_reg + CNT_W'(line_bytes_reg);
            beat_idx_reg   <= '0;
            line_data_reg  <= '0;
            line_we_reg    <= '0;
            line_bytes_reg <= '0;
            if (remaining_reg == '0) begin
              state_reg <= ST_DONE;
              done_reg  <= 1'b1;
            end else begin
              state_reg <= ST_COLLECT;
            end
          end
        end
        ST_DONE: begin
          if (ctrl_wr) begin
            state_reg <= ST_IDLE;
            done_reg  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Read data is captured from pre-edge state, so a status read racing a transition sees the old state.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_reg <= '0;
    end else if (bus.mmio_sel && bus.mmio_re) begin
      case (offset)
        OFF_CTRL:    rdata_reg <= {30'b0, done_reg, busy};
        OFF_DST:     rdata_reg <= cfg_dst_reg;
        OFF_COUNT:   rdata_reg <= 32'(cfg_count_reg);
        OFF_SCALE:   rdata_reg <= 32'(cfg_scale_reg);
        OFF_SHIFT:   rdata_reg <= {27'b0, cfg_shift_reg};
        OFF_WRITTEN: rdata_reg <= 32'(written_reg);
        default:     rdata_reg <= '0;
      endcase
    end else begin
      rdata_reg <= '0;
    end
  end

  assign bus.mmio_rdata   = rdata_reg;
  assign bus.res_ready    = (state_reg == ST_COLLECT);
  assign bus.dma_wr_valid = (state_reg == ST_WRITE);
  assign bus.dma_addr     = (state_reg == ST_WRITE) ? addr_reg : 32'd0;
  assign bus.dma_wdata    = (state_reg == ST_WRITE) ? line_data_reg : 128'd0;
  assign bus.dma_we       = (state_reg == ST_WRITE) ? line_we_reg : 16'd0;
  assign bus.wb_busy      = busy;

endmodule

// File: tb/tb_accel_result_writer.sv
// Self-checking bench for accel_result_writer: element-level requant/packing model, random jobs,
// back-pressure, abort and zero-count scenarios.
module tb_accel_result_writer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  accel_result_writer_if bus ();

  accel_result_writer #(.CNT_W(16), .SCALE_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [31:0]  addr;
    logic [127:0] data;
    logic [15:0]  we;
  } wr_t;

  int tests = 0;
  int fails = 0;

  wr_t          obs_q[$];
  wr_t          exp_q[$];
  logic [127:0] beat_q[$];
  int           acc_q[$];

  int  stall_left = 0;
  bit  rand_ready = 0;
  bit  rand_valid = 0;
  int  valid_cnt = 0;
  int  stall_seen = 0;
  int  stable_err = 0;
  int  ready_err = 0;
  bit  feeder_fire;
  bit  held = 0;
  wr_t hold_w;

  // Reference requantization on 64-bit integers.
  function automatic logic [7:0] model_rq(int acc, int scale, int shift);
    longint p;
    longint q;
    p = longint'(acc) * longint'(scale);
    if (shift > 0) p = p + (longint'(1) << (shift - 1));
    q = p >>> shift;
`ifdef ACCEL_WB_RELU_EN
    if (q < 0) q = 0;
`endif
    if (q > 127) q = 127;
    if (q < -128) q = -128;
    return 8'(q);
  endfunction

  // Result source: presents queued beats, pops one per accepted handshake.
  initial begin
    bus.res_valid = 1'b0;
    bus.res_data  = '0;
    forever begin
      @(negedge clk);
      feeder_fire = bus.res_valid && bus.res_ready;
      @(posedge clk);
      #1;
      if (feeder_fire && beat_q.size() > 0) void'(beat_q.pop_front());
      if (beat_q.size() > 0 && (!rand_valid || $urandom_range(0, 3) != 0)) begin
        bus.res_valid = 1'b1;
        bus.res_data  = beat_q[0];
      end else begin
        bus.res_valid = 1'b0;
        bus.res_data  = '0;
      end
    end
  end

  // Memory side: records accepted lines, watches stability while stalled.
  initial begin
    bus.dma_wr_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.dma_wr_valid) begin
        valid_cnt++;
        if (held && (hold_w !== {bus.dma_addr, bus.dma_wdata, bus.dma_we})) stable_err++;
        if (bus.dma_wr_ready) begin
          obs_q.push_back({bus.dma_addr, bus.dma_wdata, bus.dma_we});
          held = 0;
        end else begin
          held   = 1;
          hold_w = {bus.dma_addr, bus.dma_wdata, bus.dma_we};
          stall_seen++;
          if (bus.res_ready) ready_err++;
          if (stall_left > 0) stall_left--;
        end
      end
      @(posedge clk);
      #1;
      bus.dma_wr_ready = (stall_left == 0) && (!rand_ready || $urandom_range(0, 2) != 0);
    end
  end

  task automatic mmio_write(input logic [7:0] off, input logic [31:0] d);
    bus.mmio_sel   = 1'b1;
    bus.mmio_addr  = 32'h8000_0000 | 32'(off);
    bus.mmio_wdata = d;
    bus.mmio_we    = 4'hF;
    @(posedge clk);
    #1;
    bus.mmio_sel = 1'b0;
    bus.mmio_we  = 4'h0;
  endtask

  task automatic mmio_read(input logic [7:0] off, output logic [31:0] d);
    bus.mmio_sel  = 1'b1;
    bus.mmio_re   = 1'b1;
    bus.mmio_addr = 32'h8000_0000 | 32'(off);
    @(posedge clk);
    #1;
    bus.mmio_sel = 1'b0;
    bus.mmio_re  = 1'b0;
    d = bus.mmio_rdata;
  endtask

  task automatic wait_done(output bit timeout);
    logic [31:0] d;
    timeout = 1;
    for (int n = 0; n < 4000; n++) begin
      mmio_read(8'h00, d);
      if (d[1]) begin
        timeout = 0;
        break;
      end
    end
  endtask

  task automatic build_expected(input int count, input int scale, input int shift, input logic [31:0] dst);
    wr_t w;
    exp_q.delete();
    for (int l = 0; l < (count + 15) / 16; l++) begin
      w.addr = (dst & ~32'hF) + 32'(16 * l);
      w.data = '0;
      w.we   = '0;
      for (int b = 0; b < 16; b++) begin
        if (16 * l + b < count) begin
          w.data[8*b +: 8] = model_rq(acc_q[16*l + b], scale, shift);
          w.we[b] = 1'b1;
        end
      end
      exp_q.push_back(w);
    end
  endtask

  task automatic load_beats();
    logic [127:0] beat;
    beat_q.delete();
    for (int i = 0; i < acc_q.size(); i += 4) begin
      beat = '0;
      for (int k = 0; k < 4; k++) begin
        beat[32*k +: 32] = (i + k < acc_q.size()) ? 32'(acc_q[i + k]) : $urandom;
      end
      beat_q.push_back(beat);
    end
  endtask

  task automatic configure(input int count, input int scale, input int shift, input logic [31:0] dst);
    obs_q.delete();
    load_beats();
    build_expected(count, scale, shift, dst);
    valid_cnt = 0; stall_seen = 0; stable_err = 0; ready_err = 0; held = 0;
    mmio_write(8'h04, dst);
    mmio_write(8'h08, 32'(count));
    mmio_write(8'h0C, 32'(scale));
    mmio_write(8'h10, 32'(shift));
  endtask

  task automatic run_job(input int count, input int scale, input int shift, input logic [31:0] dst,
                         input int stall, input bit rr, input bit rv, output bit timeout);
    stall_left = stall;
    rand_ready = rr;
    rand_valid = rv;
    configure(count, scale, shift, dst);
    mmio_write(8'h00, 32'h1);
    wait_done(timeout);
    $display("[TB] job count=%0d scale=%0d shift=%0d dst=%h lines=%0d/%0d timeout=%0d",
             count, scale, shift, dst, obs_q.size(), exp_q.size(), timeout);
    if (timeout) mmio_write(8'h00, 32'h2);
  endtask

  task automatic test_reset();
    logic [31:0] d;
    bus.mmio_sel = 0; bus.mmio_addr = 0; bus.mmio_wdata = 0; bus.mmio_we = 0; bus.mmio_re = 0;
    reset = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    tests++;
    if ({bus.res_ready, bus.dma_wr_valid, bus.wb_busy} !== 3'b000 || bus.dma_addr !== 32'd0 ||
        bus.dma_we !== 16'd0 || bus.dma_wdata !== 128'd0 || bus.mmio_rdata !== 32'd0) begin
      fails++;
      $display("FAIL reset_outputs: got rr=%b v=%b busy=%b addr=%h we=%h rdata=%h, expected all 0",
               bus.res_ready, bus.dma_wr_valid, bus.wb_busy, bus.dma_addr, bus.dma_we, bus.mmio_rdata);
    end
    reset = 1'b0;
    mmio_read(8'h00, d);
    tests++;
    if (d !== 32'd0) begin fails++; $display("FAIL reset_status: got %h, expected 0", d); end
    mmio_read(8'h14, d);
    tests++;
    if (d !== 32'd0) begin fails++; $display("FAIL reset_written: got %h, expected 0", d); end
    mmio_read(8'h04, d);
    tests++;
    if (d !== 32'd0) begin fails++; $display("FAIL reset_dst: got %h, expected 0", d); end
    $display("[TB] reset checked");
  endtask

  task automatic test_full_line();
    bit to;
    logic [31:0] d;
    acc_q.delete();
    for (int i = 1; i <= 16; i++) acc_q.push_back(i);
    run_job(16, 1, 0, 32'h0000_100C, 0, 0, 0, to);
    tests++;
    if (to || obs_q.size() != 1) begin
      fails++; $display("FAIL full_line_count: got %0d lines timeout=%0d, expected 1 line", obs_q.size(), to);
    end else begin
      tests++;
      if (obs_q[0].addr !== 32'h0000_1000 || obs_q[0].we !== 16'hFFFF ||
          obs_q[0].data !== 128'h100F0E0D0C0B0A090807060504030201) begin
        fails++;
        $display("FAIL full_line_data: got addr=%h we=%h data=%h, expected addr=00001000 we=ffff data=100f0e0d0c0b0a090807060504030201",
                 obs_q[0].addr, obs_q[0].we, obs_q[0].data);
      end
    end
    mmio_read(8'h14, d);
    tests++;
    if (d !== 32'd16) begin fails++; $display("FAIL full_line_written: got %0d, expected 16", d); end
    mmio_read(8'h00, d);
    tests++;
    if (d !== 32'd2) begin fails++; $display("FAIL full_line_status: got %h, expected 2", d); end
  endtask

  task automatic test_partial_line();
    bit to;
    logic [31:0] d;
    acc_q.delete();
    for (int i = 0; i < 8; i++) acc_q.push_back(int'($urandom_range(0, 400)) - 200);
    run_job(6, 1, 0, 32'h0000_2000, 0, 0, 0, to);
    tests++;
    if (to || obs_q.size() != 1) begin
      fails++; $display("FAIL partial_count: got %0d lines timeout=%0d, expected 1 line", obs_q.size(), to);
    end else begin
      tests++;
      if (obs_q[0].we !== 16'h003F || obs_q[0] !== exp_q[0]) begin
        fails++;
        $display("FAIL partial_line: got we=%h data=%h, expected we=003f data=%h",
                 obs_q[0].we, obs_q[0].data, exp_q[0].data);
      end
    end
    tests++;
    if (beat_q.size() != 0) begin fails++; $display("FAIL partial_beats: got %0d left, expected 0", beat_q.size()); end
    mmio_read(8'h14, d);
    tests++;
    if (d !== 32'd6) begin fails++; $display("FAIL partial_written: got %0d, expected 6", d); end
  endtask

  task automatic test_requant();
    bit to;
    logic [31:0] exp_neg;
`ifdef ACCEL_WB_RELU_EN
    exp_neg = 32'h0000_0000;
`else
    exp_neg = 32'h0000_0080;
`endif
    acc_q = '{300, -300, 127, -128};
    run_job(4, 1, 0, 32'h0000_3000, 0, 0, 0, to);
    tests++;
    if (to || obs_q.size() != 1 || obs_q[0].data[7:0] !== 8'h7F || obs_q[0].data[15:8] !== exp_neg[7:0] ||
        obs_q[0] !== exp_q[0]) begin
      fails++;
      $display("FAIL requant_saturate: got lines=%0d data=%h, expected byte0=7f byte1=%h data=%h",
               obs_q.size(), (obs_q.size() > 0) ? obs_q[0].data : 128'd0, exp_neg[7:0], exp_q[0].data);
    end
    acc_q = '{5, -5, 1000, 0};
    run_job(4, 3, 1, 32'h0000_3010, 0, 0, 0, to);
    tests++;
    if (to || obs_q.size() != 1 || obs_q[0].data[7:0] !== 8'h08 || obs_q[0] !== exp_q[0]) begin
      fails++;
      $display("FAIL requant_round: got lines=%0d data=%h, expected byte0=08 data=%h",
               obs_q.size(), (obs_q.size() > 0) ? obs_q[0].data : 128'd0, exp_q[0].data);
    end
  endtask

  task automatic test_backpressure();
    bit to;
    logic [31:0] d;
    acc_q.delete();
    for (int i = 0; i < 32; i++) acc_q.push_back(int'($urandom_range(0, 600)) - 300);
    run_job(32, 1, 0, 32'h0000_4000, 5, 0, 0, to);
    tests++;
    if (to || stall_seen != 5 || stable_err != 0 || ready_err != 0) begin
      fails++;
      $display("FAIL backpressure_hold: got stalls=%0d unstable=%0d ready_during_stall=%0d timeout=%0d, expected 5/0/0/0",
               stall_seen, stable_err, ready_err, to);
    end
    tests++;
    if (obs_q.size() != 2) begin
      fails++; $display("FAIL backpressure_count: got %0d lines, expected 2", obs_q.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        tests++;
        if (obs_q[i] !== exp_q[i]) begin
          fails++;
          $display("FAIL backpressure_line%0d: got addr=%h we=%h data=%h, expected addr=%h we=%h data=%h",
                   i, obs_q[i].addr, obs_q[i].we, obs_q[i].data, exp_q[i].addr, exp_q[i].we, exp_q[i].data);
        end
      end
      tests++;
      if (obs_q[1].addr !== 32'h0000_4010) begin
        fails++; $display("FAIL backpressure_addr2: got %h, expected 00004010", obs_q[1].addr);
      end
    end
    mmio_read(8'h14, d);
    tests++;
    if (d !== 32'd32) begin fails++; $display("FAIL backpressure_written: got %0d, expected 32", d); end
  endtask

  task automatic test_abort();
    logic [31:0] d;
    int n;
    stall_left = 0; rand_ready = 0; rand_valid = 0;
    acc_q.delete();
    for (int i = 0; i < 8; i++) acc_q.push_back(i + 1);
    configure(16, 1, 0, 32'h0000_5000);
    mmio_write(8'h00, 32'h1);
    for (n = 0; n < 200 && beat_q.size() != 0; n++) begin
      @(posedge clk);
      #1;
    end
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (n >= 200 || !bus.res_ready || !bus.wb_busy) begin
      fails++; $display("FAIL abort_collecting: got rr=%b busy=%b wait=%0d, expected 1/1 within 200", bus.res_ready, bus.wb_busy, n);
    end
    mmio_write(8'h00, 32'h3);
    tests++;
    if (bus.res_ready || bus.wb_busy || bus.dma_wr_valid) begin
      fails++; $display("FAIL abort_idle: got rr=%b busy=%b v=%b, expected 0/0/0", bus.res_ready, bus.wb_busy, bus.dma_wr_valid);
    end
    mmio_read(8'h00, d);
    tests++;
    if (d !== 32'd0) begin fails++; $display("FAIL abort_status: got %h, expected 0", d); end
    repeat (10) @(posedge clk);
    #1;
    tests++;
    if (valid_cnt != 0) begin fails++; $display("FAIL abort_nowrite: got %0d valid cycles, expected 0", valid_cnt); end
    $display("[TB] abort after 2 beats checked");
  endtask

  task automatic test_zero_count();
    logic [31:0] d;
    acc_q.delete();
    configure(0, 1, 0, 32'h0000_6000);
    mmio_write(8'h00, 32'h1);
    mmio_read(8'h00, d);
    tests++;
    if (d !== 32'd2) begin fails++; $display("FAIL zero_status: got %h, expected 2", d); end
    mmio_read(8'h14, d);
    tests++;
    if (d !== 32'd0) begin fails++; $display("FAIL zero_written: got %0d, expected 0", d); end
    tests++;
    if (valid_cnt != 0) begin fails++; $display("FAIL zero_nowrite: got %0d valid cycles, expected 0", valid_cnt); end
    mmio_write(8'h00, 32'h0);
    mmio_read(8'h00, d);
    tests++;
    if (d !== 32'd0) begin fails++; $display("FAIL done_clear: got %h, expected 0", d); end
    $display("[TB] zero-count job checked");
  endtask

  task automatic test_random(input int jobs, input bit rr, input bit rv);
    bit to;
    logic [31:0] d;
    int count;
    for (int j = 0; j < jobs; j++) begin
      count = int'($urandom_range(1, 72));
      acc_q.delete();
      for (int i = 0; i < ((count + 3) / 4) * 4; i++)
        acc_q.push_back($urandom_range(0, 1) ? int'($urandom) : int'($urandom_range(0, 2000)) - 1000);
      run_job(count, int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 15)),
              32'h0001_0000 + 32'($urandom_range(0, 4095)), 0, rr, rv, to);
      tests++;
      if (to || obs_q.size() != exp_q.size()) begin
        fails++; $display("FAIL random_count: got %0d lines timeout=%0d, expected %0d", obs_q.size(), to, exp_q.size());
      end else begin
        for (int i = 0; i < exp_q.size(); i++) begin
          tests++;
          if (obs_q[i] !== exp_q[i]) begin
            fails++;
            $display("FAIL random_line%0d: got addr=%h we=%h data=%h, expected addr=%h we=%h data=%h",
                     i, obs_q[i].addr, obs_q[i].we, obs_q[i].data, exp_q[i].addr, exp_q[i].we, exp_q[i].data);
          end
        end
      end
      mmio_read(8'h14, d);
      tests++;
      if (d !== 32'(count)) begin fails++; $display("FAIL random_written: got %0d, expected %0d", d, count); end
    end
  endtask

  initial begin
    bus.mmio_sel = 0; bus.mmio_addr = 0; bus.mmio_wdata = 0; bus.mmio_we = 0; bus.mmio_re = 0;
    @(posedge clk);
    #1;
    test_reset();
    test_full_line();
    test_partial_line();
    test_requant();
    test_backpressure();
    test_abort();
    test_full_line();
    test_zero_count();
    test_random(3, 0, 0);
    test_random(6, 1, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
